tm11_gen: RTL and testbench

- Parametrised next-generation TM11/TU10 magtape register interface for the Zynq PDP-11/34 design.
- Sits on the Unibus slave side; exposes registers MTS, MTC, MTBRC, MTCMA, MTD, MTRD to the PDP and a 3-bit-address word window to the ARM, which performs the tape transfers.
- New over the previous generation:
  - drive count is a parameter;
  - GO to a non-existent or unselected drive is rejected in hardware;
  - the MTRD[15] tick rate is a parameter;
  - an optional ARM-response watchdog.

---
 rtl/tm11_gen_pkg.sv | 46 ++++
 rtl/tm11_gen_intreq.sv | 44 ++++
 rtl/tm11_gen.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_tm11_gen.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tm11_gen_pkg.sv
// tm11_gen_pkg: shared constants for the TM11/TU10 magtape register interface.
//   - Unibus register offsets (word index a[3:1]) and ARM word indexes
//   - MTS/MTC bit positions, bus read masks, ARM-visible ID word
//   - drive_mask(): bit mask of the transports that exist for a drive count
package tm11_gen_pkg;

    // Unibus register offsets, indexed by a[3:1]
    localparam logic [2:0] OFF_MTS   = 3'd0;
    localparam logic [2:0] OFF_MTC   = 3'd1;
    localparam logic [2:0] OFF_MTBRC = 3'd2;
    localparam logic [2:0] OFF_MTCMA = 3'd3;
    localparam logic [2:0] OFF_MTD   = 3'd4;
    localparam logic [2:0] OFF_MTRD  = 3'd5;

    // ARM word window indexes
    localparam logic [2:0] ARM_ID     = 3'd0;
    localparam logic [2:0] ARM_CTLSTS = 3'd1;
    localparam logic [2:0] ARM_BRCCMA = 3'd2;
    localparam logic [2:0] ARM_RDD    = 3'd3;
    localparam logic [2:0] ARM_CFG    = 3'd4;
    localparam logic [2:0] ARM_DRVST  = 3'd5;
    localparam logic [2:0] ARM_SELS   = 3'd6;
    localparam logic [2:0] ARM_WDCNT  = 3'd7;

    // MTS / MTC bit positions
    localparam int BIT_ILC  = 15;
    localparam int BIT_PCLR = 12;
    localparam int BIT_CUR  = 7;
    localparam int BIT_IE   = 6;
    localparam int BIT_GO   = 0;

    // Bus read masks: MTC hides power-clear and GO, MTCMA is word aligned
    localparam logic [15:0] MTC_RDMASK   = 16'o167776;
    localparam logic [15:0] MTCMA_RDMASK = 16'o177776;

    localparam logic [31:0] TM11_ID   = 32'h544D2002;
    localparam logic [14:0] MTC_RESET = 15'o10000;

    // One bit per existing transport; NDRIVES=8 gives 8'hFF
    function automatic logic [7:0] drive_mask(input int n);
        logic [8:0] m;
        m = (9'd1 << n) - 9'd1;
        return m[7:0];
    endfunction

endpackage

// File: rtl/tm11_gen_intreq.sv
// intreq: edge-triggered Unibus interrupt requester.
//   CLOCK, RESET (async active-low), INIT (sync clear)
//   irqlevel : interrupt condition level; a rising edge raises the request
//   intreq   : request to the bus arbiter
//   irvec    : vector presented while requesting, else 0
//   intgnt/igvec : grant strobe and granted vector; matching grant drops request
module intreq #(
    parameter logic [7:0] VECTOR = 8'o0
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       INIT,
    input  logic       irqlevel,
    output logic       intreq,
    output logic [7:0] irvec,
    input  logic       intgnt,
    input  logic [7:0] igvec
);

    logic r_last_level;
    logic r_intreq;

    // Request flop: set on level rising edge, dropped by a grant for our vector
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_last_level <= 1'b0;
            r_intreq     <= 1'b0;
        end else if (INIT) begin
            r_last_level <= 1'b0;
            r_intreq     <= 1'b0;
        end else begin
            r_last_level <= irqlevel;
            if (intgnt && (igvec == VECTOR)) begin
                r_intreq <= 1'b0;
            end else if (irqlevel && !r_last_level) begin
                r_intreq <= 1'b1;
            end
        end
    end

    assign intreq = r_intreq;
    assign irvec  = r_intreq ? VECTOR : 8'h00;

endmodule

// File: rtl/tm11_gen.sv
// tm11_gen: TM11/TU10 magtape register interface (Unibus slave + ARM window).
//   PDP side : MTS, MTC, MTBRC, MTCMA, MTD, MTRD at ADDR..ADDR+12
//   ARM side : 8-word window (armraddr/armwaddr), armintrq wakes the ARM
//   Ports    : CLOCK, RESET (async active-low), arm* ARM access,
//              intreq/irvec/intgnt/igvec interrupt, a/c/d/init/msyn bus in,
//              d_out_h/ssyn_out_h bus out (registered)
//   Build option: define TM11G_WATCHDOG_EN to add the ARM-response watchdog.
module tm11_gen
    import tm11_gen_pkg::*;
#(
    parameter logic [17:0] ADDR     = 18'o772520,
    parameter logic [7:0]  INTVEC   = 8'o224,
    parameter int          NDRIVES  = 8,
    parameter int          TICKDIV  = 500000,
    parameter int          WDCYCLES = 100000000
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        armwrite,
    input  logic [2:0]  armraddr,
    input  logic [2:0]  armwaddr,
    input  logic [31:0] armwdata,
    output logic [31:0] armrdata,
    output logic        armintrq,
    output logic        intreq,
    output logic [7:0]  irvec,
    input  logic        intgnt,
    input  logic [7:0]  igvec,
    input  logic [17:0] a_in_h,
    input  logic [1:0]  c_in_h,
    input  logic [15:0] d_in_h,
    input  logic        init_in_h,
    input  logic        msyn_in_h,
    output logic [15:0] d_out_h,
    output logic        ssyn_out_h
);

    localparam logic [7:0]  DRV_MASK  = drive_mask(NDRIVES);
    localparam logic [2:0]  NDRV_M1   = 3'(NDRIVES - 1);
    localparam logic [31:0] TICK_LAST = 32'(TICKDIV - 1);

    logic        r_enable, r_fastio;
    logic [7:0]  r_sels, r_bots, r_wrls, r_rews, r_turs;
    logic [15:7] r_mts_hi;
    logic [14:0] r_mtc;
    logic [15:0] r_mtbrc, r_mtcma, r_mtd;
    logic [14:0] r_mtrd;
    logic        r_tick;
    logic [31:0] r_tick_cnt;
    logic [15:0] r_d_out;
    logic        r_ssyn;

    logic [2:0]  w_unit;
    logic [15:0] w_mts, w_mtc, w_mtrd;
    logic        w_bus_sel, w_wr, w_writehi, w_writelo;
    logic [2:0]  w_off;
    logic [15:0] w_bus_rdata;
    logic [2:0]  w_go_unit;
    logic        w_go_rise, w_go_ok;
    logic        w_irq_level;
    logic        w_wdtrip, w_wd_fire;
    logic [31:0] w_wd_cnt;

    // Drive status seen by the PDP follows the unit selected in MTC; arrays
    // are kept zero above NDRIVES so absent units read as all-zero.
    assign w_unit = r_mtc[10:8];
    assign w_mts  = {r_mts_hi, r_sels[w_unit], r_bots[w_unit], 2'b00,
                     r_wrls[w_unit], r_rews[w_unit], r_turs[w_unit]};
    assign w_mtc  = {|r_mts_hi, r_mtc};
    assign w_mtrd = {r_tick, r_mtrd};

    assign w_off     = a_in_h[3:1];
    assign w_wr      = c_in_h[1];
    assign w_writehi = ~c_in_h[0] | a_in_h[0];
    assign w_writelo = ~c_in_h[0] | ~a_in_h[0];
    assign w_bus_sel = msyn_in_h & r_enable & (a_in_h[17:4] == ADDR[17:4]) & ~r_ssyn;

    // GO targets the unit being written in the same cycle when the high byte is written
    assign w_go_unit = w_writehi ? d_in_h[10:8] : r_mtc[10:8];
    assign w_go_rise = w_writelo & d_in_h[BIT_GO] & ~r_mtc[BIT_GO];
    assign w_go_ok   = DRV_MASK[w_go_unit] & r_sels[w_go_unit];

    assign w_irq_level = (w_mtc[BIT_ILC] | r_mtc[BIT_CUR]) & r_mtc[BIT_IE];
    assign armintrq    = r_mtc[BIT_GO] | r_mtc[BIT_PCLR];

`ifdef TM11G_WATCHDOG_EN
    localparam logic [31:0] WD_LIMIT = 32'(WDCYCLES);
    logic        r_wdtrip;
    logic [31:0] r_wd_cnt;

    // Watchdog counter: runs while GO is set, saturates at the limit
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_wd_cnt <= 32'd0;
        end else if (init_in_h || !r_mtc[BIT_GO]) begin
            r_wd_cnt <= 32'd0;
        end else if (r_wd_cnt != WD_LIMIT) begin
            r_wd_cnt <= r_wd_cnt + 32'd1;
        end
    end

    assign w_wd_fire = r_mtc[BIT_GO] & (r_wd_cnt == WD_LIMIT);
    assign w_wdtrip  = r_wdtrip;
    assign w_wd_cnt  = r_wd_cnt;
`else
    assign w_wd_fire = 1'b0;
    assign w_wdtrip  = 1'b0;
    assign w_wd_cnt  = 32'd0;
`endif

    // Bus read data for the addressed register
    always_comb begin
        w_bus_rdata = 16'h0000;
        case (w_off)
            OFF_MTS:   w_bus_rdata = w_mts;
            OFF_MTC:   w_bus_rdata = w_mtc & MTC_RDMASK;
            OFF_MTBRC: w_bus_rdata = r_mtbrc;
            OFF_MTCMA: w_bus_rdata = r_mtcma & MTCMA_RDMASK;
            OFF_MTD:   w_bus_rdata = r_mtd;
            OFF_MTRD:  w_bus_rdata = w_mtrd;
            default:   w_bus_rdata = 16'h0000;
        endcase
    end

    // ARM read window
    always_comb begin
        armrdata = 32'h0000_0000;
        case (armraddr)
            ARM_ID:     armrdata = TM11_ID;
            ARM_CTLSTS: armrdata = {w_mtc, w_mts};
            ARM_BRCCMA: armrdata = {r_mtcma, r_mtbrc};
            ARM_RDD:    armrdata = {w_mtrd, r_mtd};
            ARM_CFG:    armrdata = {r_enable, r_fastio, w_wdtrip, NDRV_M1, INTVEC, ADDR};
            ARM_DRVST:  armrdata = {r_bots, r_wrls, r_rews, r_turs};
            ARM_SELS:   armrdata = {24'h000000, r_sels};
            ARM_WDCNT:  armrdata = w_wd_cnt;
            default:    armrdata = 32'h0000_0000;
        endcase
    end

    // Register file: INIT, then ARM writes, then watchdog trip, then the bus.
    // A lower-priority action simply waits a cycle.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_enable <= 1'b0;
            r_fastio <= 1'b0;
            r_sels   <= 8'h00;
            r_bots   <= 8'h00;
            r_wrls   <= 8'h00;
            r_rews   <= 8'h00;
            r_turs   <= 8'h00;
            r_mts_hi <= 9'h000;
            r_mtc    <= MTC_RESET;
            r_mtbrc  <= 16'h0000;
            r_mtcma  <= 16'h0000;
            r_mtd    <= 16'h0000;
            r_mtrd   <= 15'h0000;
            r_d_out  <= 16'h0000;
            r_ssyn   <= 1'b0;
`ifdef TM11G_WATCHDOG_EN
            r_wdtrip <= 1'b0;
`endif
        end else if (init_in_h) begin
            // Bus INIT leaves the ARM's configuration and drive status alone
            r_mts_hi <= 9'h000;
            r_mtc    <= MTC_RESET;
            r_mtbrc  <= 16'h0000;
            r_mtcma  <= 16'h0000;
            r_mtd    <= 16'h0000;
            r_mtrd   <= 15'h0000;
            r_d_out  <= 16'h0000;
            r_ssyn   <= 1'b0;
`ifdef TM11G_WATCHDOG_EN
            r_wdtrip <= 1'b0;
`endif
        end else if (armwrite) begin
            case (armwaddr)
                ARM_CTLSTS: begin
                    r_mtc    <= armwdata[30:16];
                    // ILC is sticky so the ARM cannot lose one raised by the bus
                    r_mts_hi <= {r_mts_hi[BIT_ILC] | armwdata[15], armwdata[14:7]};
                end
                ARM_BRCCMA: begin
                    r_mtcma <= armwdata[31:16] & MTCMA_RDMASK;
                    r_mtbrc <= armwdata[15:0];
                end
                ARM_RDD: begin
                    r_mtrd <= armwdata[30:16];
                    r_mtd  <= armwdata[15:0];
                end
                ARM_CFG: begin
                    r_enable <= armwdata[31];
                    r_fastio <= armwdata[30];
`ifdef TM11G_WATCHDOG_EN
                    if (armwdata[29]) begin
                        r_wdtrip <= 1'b0;
                    end
`endif
                end
                ARM_DRVST: begin
                    r_bots <= armwdata[31:24] & DRV_MASK;
                    r_wrls <= armwdata[23:16] & DRV_MASK;
                    r_rews <= armwdata[15:8]  & DRV_MASK;
                    r_turs <= armwdata[7:0]   & DRV_MASK;
                end
                ARM_SELS: r_sels <= armwdata[7:0] & DRV_MASK;
                default: ;
            endcase
        end else if (w_wd_fire) begin
`ifdef TM11G_WATCHDOG_EN
            r_mts_hi[BIT_ILC] <= 1'b1;
            r_mtc[BIT_GO]     <= 1'b0;
            r_mtc[BIT_CUR]    <= 1'b1;
            r_wdtrip          <= 1'b1;
`endif
        end else if (!msyn_in_h) begin
            r_d_out <= 16'h0000;
            r_ssyn  <= 1'b0;
        end else if (w_bus_sel) begin
            r_ssyn <= 1'b1;
            if (!w_wr) begin
                r_d_out <= w_bus_rdata;
            end else begin
                case (w_off)
                    OFF_MTC: begin
                        if (w_writehi && d_in_h[BIT_PCLR]) begin
                            // Power clear: hand the controller back to the ARM
                            r_mts_hi      <= 9'h000;
                            r_mtc[14:8]   <= d_in_h[14:8];
                            r_mtc[BIT_GO] <= 1'b0;
                            if (w_writelo) begin
                                r_mtc[6:1] <= d_in_h[6:1];
                            end
                        end else if (!r_mtc[BIT_CUR]) begin
                            r_mts_hi[BIT_ILC] <= 1'b1;
                        end else begin
                            if (w_writehi) begin
                                r_mtc[14:8] <= d_in_h[14:8];
                            end
                            if (w_writelo) begin
                                r_mtc[6:0] <= d_in_h[6:0];
                            end
                            if (w_go_rise) begin
                                if (w_go_ok) begin
                                    r_mtc[BIT_CUR]     <= 1'b0;
                                    r_mts_hi           <= 9'h000;
                                    r_turs[w_go_unit]  <= 1'b0;
                                end else begin
                                    // Bad unit: refuse without waking the ARM
                                    r_mts_hi[BIT_ILC] <= 1'b1;
                                    r_mtc[BIT_GO]     <= 1'b0;
                                end
                            end
                        end
                    end
                    OFF_MTBRC: begin
                        if (w_writehi) begin
                            r_mtbrc[15:8] <= d_in_h[15:8];
                        end
                        if (w_writelo) begin
                            r_mtbrc[7:0] <= d_in_h[7:0];
                        end
                    end
                    OFF_MTCMA: begin
                        if (w_writehi) begin
                            r_mtcma[15:8] <= d_in_h[15:8];
                        end
                        if (w_writelo) begin
                            r_mtcma[7:0] <= {d_in_h[7:1], 1'b0};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // MTRD[15] square wave: toggles once every TICKDIV cycles
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_tick_cnt <= 32'd0;
            r_tick     <= 1'b0;
        end else if (init_in_h) begin
            r_tick_cnt <= 32'd0;
            r_tick     <= 1'b0;
        end else if (r_tick_cnt == TICK_LAST) begin
            r_tick_cnt <= 32'd0;
            r_tick     <= ~r_tick;
        end else begin
            r_tick_cnt <= r_tick_cnt + 32'd1;
        end
    end

    assign d_out_h    = r_d_out;
    assign ssyn_out_h = r_ssyn;

    intreq #(
        .VECTOR (INTVEC)
    ) u_intreq (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .INIT     (init_in_h),
        .irqlevel (w_irq_level),
        .intreq   (intreq),
        .irvec    (irvec),
        .intgnt   (intgnt),
        .igvec    (igvec)
    );

endmodule

// File: tb/tb_tm11_gen.sv
// tb_tm11_gen: directed bench for tm11_gen (NDRIVES=4, TICKDIV=10, WDCYCLES=50).
module tb_tm11_gen;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        armwrite;
    logic [2:0]  armraddr, armwaddr;
    logic [31:0] armwdata, armrdata;
    logic        armintrq, intreq, intgnt;
    logic [7:0]  irvec, igvec;
    logic [17:0] a_in_h;
    logic [1:0]  c_in_h;
    logic [15:0] d_in_h, d_out_h;
    logic        init_in_h, msyn_in_h, ssyn_out_h;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] rd32;
    logic [15:0] brd;
    logic        bok, bheld, brel;
    int          d1, d2, dsync;

    localparam logic [31:0] CFG_BASE = {3'b000, 3'd3, 8'o224, 18'o772520};

    always #5 CLOCK = ~CLOCK;

    tm11_gen #(
        .NDRIVES  (4),
        .TICKDIV  (10),
        .WDCYCLES (50)
    ) dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .armwrite   (armwrite),
        .armraddr   (armraddr),
        .armwaddr   (armwaddr),
        .armwdata   (armwdata),
        .armrdata   (armrdata),
        .armintrq   (armintrq),
        .intreq     (intreq),
        .irvec      (irvec),
        .intgnt     (intgnt),
        .igvec      (igvec),
        .a_in_h     (a_in_h),
        .c_in_h     (c_in_h),
        .d_in_h     (d_in_h),
        .init_in_h  (init_in_h),
        .msyn_in_h  (msyn_in_h),
        .d_out_h    (d_out_h),
        .ssyn_out_h (ssyn_out_h)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic arm_wr(input logic [2:0] ad, input logic [31:0] dat);
        @(negedge CLOCK);
        armwrite = 1'b1;
        armwaddr = ad;
        armwdata = dat;
        @(negedge CLOCK);
        armwrite = 1'b0;
    endtask

    task automatic arm_rd(input logic [2:0] ad, output logic [31:0] dat);
        armraddr = ad;
        #1;
        dat = armrdata;
    endtask

    task automatic init_pulse();
        @(negedge CLOCK);
        init_in_h = 1'b1;
        @(negedge CLOCK);
        init_in_h = 1'b0;
    endtask

    task automatic bus_cycle(input logic [17:0] addr, input logic [1:0] ctl, input logic [15:0] wd,
                             input int hold, output logic [15:0] rd, output logic ok,
                             output logic held, output logic rel);
        int n;
        @(negedge CLOCK);
        a_in_h    = addr;
        c_in_h    = ctl;
        d_in_h    = wd;
        msyn_in_h = 1'b1;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 8) begin
            @(negedge CLOCK);
            n++;
            ok = ssyn_out_h;
        end
        rd = d_out_h;
        repeat (hold) @(negedge CLOCK);
        held = ssyn_out_h;
        msyn_in_h = 1'b0;
        @(negedge CLOCK);
        rel = ~ssyn_out_h & (d_out_h == 16'h0000);
    endtask

    task automatic bus_rd(input string tag, input logic [17:0] addr, input logic [15:0] exp);
        bus_cycle(addr, 2'b00, 16'h0000, 0, brd, bok, bheld, brel);
        check({tag, "_ssyn"}, {31'd0, bok}, 32'd1);
        check(tag, {16'h0000, brd}, {16'h0000, exp});
    endtask

    task automatic bus_wr(input string tag, input logic [17:0] addr, input logic [1:0] ctl,
                          input logic [15:0] dat);
        bus_cycle(addr, ctl, dat, 0, brd, bok, bheld, brel);
        check({tag, "_ssyn"}, {31'd0, bok}, 32'd1);
    endtask

    // Cycles until MTRD[15] next changes (999 if it never does)
    task automatic tick_gap(output int cyc);
        logic prev;
        logic [31:0] v;
        arm_rd(3'd3, v);
        prev = v[31];
        cyc  = 999;
        for (int i = 1; i <= 100; i++) begin
            @(negedge CLOCK);
            arm_rd(3'd3, v);
            if (v[31] != prev) begin
                cyc = i;
                break;
            end
        end
    endtask

    initial begin
        RESET = 1'b0;
        armwrite = 1'b0; armraddr = 3'd0; armwaddr = 3'd0; armwdata = 32'd0;
        intgnt = 1'b0; igvec = 8'd0;
        a_in_h = 18'd0; c_in_h = 2'b00; d_in_h = 16'd0;
        init_in_h = 1'b0; msyn_in_h = 1'b0;
        repeat (3) @(negedge CLOCK);
        RESET = 1'b1;

        // Reset state
        arm_rd(3'd0, rd32); check("rst_id", rd32, 32'h544D2002);
        arm_rd(3'd1, rd32); check("rst_ctlsts", rd32, 32'h1000_0000);
        arm_rd(3'd4, rd32); check("rst_cfg", rd32, CFG_BASE);
        arm_rd(3'd7, rd32); check("rst_wdcnt", rd32, 32'd0);
        check("rst_ssyn", {31'd0, ssyn_out_h}, 32'd0);
        check("rst_dout", {16'd0, d_out_h}, 32'd0);
        check("rst_armintrq", {31'd0, armintrq}, 32'd1);
        check("rst_intreq", {31'd0, intreq}, 32'd0);

        // Disabled interface ignores the bus
        bus_cycle(18'o772522, 2'b00, 16'h0000, 0, brd, bok, bheld, brel);
        check("dis_nossyn", {31'd0, bok}, 32'd0);

        // Enable, set CUR, read MTC and hold the cycle
        arm_wr(3'd4, 32'h8000_0000);
        arm_wr(3'd1, {16'o000200, 16'h0000});
        bus_cycle(18'o772522, 2'b00, 16'h0000, 3, brd, bok, bheld, brel);
        check("mtc_rd_ssyn", {31'd0, bok}, 32'd1);
        check("mtc_rd", {16'd0, brd}, {16'd0, 16'o000200});
        check("ssyn_held", {31'd0, bheld}, 32'd1);
        check("ssyn_release", {31'd0, brel}, 32'd1);
        check("idle_armintrq", {31'd0, armintrq}, 32'd0);

        // Drive arrays clipped to NDRIVES
        arm_wr(3'd5, 32'hFFFF_FFFF);
        arm_rd(3'd5, rd32); check("drvst_mask", rd32, 32'h0F0F_0F0F);
        arm_wr(3'd6, 32'h0000_00FF);
        arm_rd(3'd6, rd32); check("sels_mask", rd32, 32'h0000_000F);
        arm_wr(3'd5, 32'h0000_0001);
        arm_wr(3'd6, 32'h0000_0001);

        // GO to unit 0
        bus_wr("go_wr", 18'o772522, 2'b10, 16'o000001);
        arm_rd(3'd1, rd32); check("go_ctlsts", rd32, 32'h0001_0040);
        arm_rd(3'd5, rd32); check("go_turs", rd32, 32'h0000_0000);
        check("go_armintrq", {31'd0, armintrq}, 32'd1);

        // Write while busy -> ILC
        bus_wr("busy_wr", 18'o772522, 2'b10, 16'o000001);
        bus_rd("busy_mts", 18'o772520, 16'o100100);
        bus_rd("busy_mtc", 18'o772522, 16'o100000);

        // INIT keeps enable and drive arrays
        init_pulse();
        arm_rd(3'd1, rd32); check("init_ctlsts", rd32, 32'h1000_0040);
        arm_rd(3'd4, rd32); check("init_cfg", rd32, CFG_BASE | 32'h8000_0000);

        // GO to non-existent unit 5
        arm_wr(3'd1, {16'o000200, 16'h0000});
        bus_wr("badu_wr", 18'o772522, 2'b10, 16'o002401);
        arm_rd(3'd1, rd32); check("badu_ctlsts", rd32, {16'o102600, 16'o100000});
        check("badu_armintrq", {31'd0, armintrq}, 32'd0);

        // Byte lanes and read-only registers
        bus_wr("brc_hi_wr", 18'o772525, 2'b11, 16'o177400);
        bus_rd("brc_hi", 18'o772524, 16'o177400);
        bus_wr("brc_lo_wr", 18'o772524, 2'b11, 16'o000125);
        bus_rd("brc_lo", 18'o772524, 16'o177525);
        bus_wr("cma_wr", 18'o772526, 2'b10, 16'o001235);
        bus_rd("cma_rd", 18'o772526, 16'o001234);
        bus_wr("mtd_wr", 18'o772530, 2'b10, 16'o001234);
        bus_rd("mtd_ro", 18'o772530, 16'o000000);
        bus_rd("off6", 18'o772534, 16'o000000);
        bus_rd("off7", 18'o772536, 16'o000000);

        // Interrupt on CUR rising with IE set
        init_pulse();
        arm_wr(3'd1, {16'o000100, 16'h0000});
        repeat (2) @(negedge CLOCK);
        check("irq_idle", {31'd0, intreq}, 32'd0);
        arm_wr(3'd1, {16'o000300, 16'h0000});
        repeat (2) @(negedge CLOCK);
        check("irq_req", {31'd0, intreq}, 32'd1);
        check("irq_vec", {24'd0, irvec}, {24'd0, 8'o224});
        intgnt = 1'b1; igvec = 8'o220;
        @(negedge CLOCK);
        intgnt = 1'b0;
        @(negedge CLOCK);
        check("irq_wrong_gnt", {31'd0, intreq}, 32'd1);
        intgnt = 1'b1; igvec = 8'o224;
        @(negedge CLOCK);
        intgnt = 1'b0;
        @(negedge CLOCK);
        check("irq_gnt", {31'd0, intreq}, 32'd0);
        check("irq_gnt_vec", {24'd0, irvec}, 32'd0);

        // Power clear while busy
        bus_wr("pc_go", 18'o772522, 2'b10, 16'o000001);
        bus_wr("pc_busy", 18'o772522, 2'b10, 16'o000001);
        arm_rd(3'd1, rd32); check("pc_pre", rd32, 32'h8001_8040);
        bus_wr("pc_wr", 18'o772523, 2'b11, 16'o010000);
        arm_rd(3'd1, rd32); check("pc_ctlsts", rd32, 32'h1000_0040);
        check("pc_armintrq", {31'd0, armintrq}, 32'd1);

        // MTRD[15] tick
        tick_gap(dsync);
        tick_gap(d1);
        tick_gap(d2);
        check("tick_half", d1, 32'd10);
        check("tick_period", d1 + d2, 32'd20);

        // Watchdog (or its absence)
        init_pulse();
        arm_wr(3'd1, {16'o000200, 16'h0000});
        bus_wr("wd_go", 18'o772522, 2'b10, 16'o000001);
        repeat (40) @(negedge CLOCK);
        arm_rd(3'd1, rd32); check("wd_running", rd32, 32'h0001_0040);
        arm_rd(3'd7, rd32);
`ifdef TM11G_WATCHDOG_EN
        check("wd_count", rd32, 32'd41);
`else
        check("wd_count", rd32, 32'd0);
`endif
        repeat (20) @(negedge CLOCK);
`ifdef TM11G_WATCHDOG_EN
        arm_rd(3'd1, rd32); check("wd_trip_ctlsts", rd32, 32'h8080_8040);
        arm_rd(3'd4, rd32); check("wd_trip_cfg", rd32, CFG_BASE | 32'hA000_0000);
        arm_wr(3'd4, 32'hA000_0000);
        arm_rd(3'd4, rd32); check("wd_clear_cfg", rd32, CFG_BASE | 32'h8000_0000);
`else
        arm_rd(3'd1, rd32); check("wd_none_ctlsts", rd32, 32'h0001_0040);
        arm_rd(3'd4, rd32); check("wd_none_cfg", rd32, CFG_BASE | 32'h8000_0000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
